// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud divider helper
// also used by the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    function automatic int unsigned baud_cnt(input int unsigned sys_clk,
                                             input int unsigned baud);
        return sys_clk / baud - 1;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle level (1).
module uart_sync (
    input  logic clock,
    input  logic nRst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock) begin
        if (!nRst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready byte output, sticky framing and
// overrun flags, and an interrupt that ORs the three status flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK = 50000000,
    parameter int unsigned BAUD    = 9600
) (
    input  logic       clock,
    input  logic       nRst,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic       frame_err,
    output logic       overrun,
    output logic       interrupt
);

    localparam int unsigned BIT_CNT  = baud_cnt(SYS_CLK, BAUD);
    localparam int unsigned HALF_CNT = BIT_CNT / 2;

    logic        w_rx_s;
    rx_state_e   r_state;
    rx_state_e   w_state_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        w_load;
    logic        w_ferr_set;
    logic        w_ovr_set;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        r_ovr;

    uart_sync u_sync (
        .clock   (clock),
        .nRst    (nRst),
        .i_async (RX),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clock) begin
        if (!nRst) begin
            r_state <= IDLE;
            r_cnt   <= 32'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 32'd1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_ferr_set  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = 32'd0;
                if (!w_rx_s) w_state_nxt = START;
            end
            START: begin
                // Re-check the start bit at its midpoint; a high line here was a glitch.
                if (r_cnt == HALF_CNT) begin
                    w_cnt_nxt = 32'd0;
                    if (!w_rx_s) begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (r_cnt == BIT_CNT) begin
                    w_cnt_nxt   = 32'd0;
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state_nxt = STOP;
                    else               w_bit_nxt   = r_bit + 3'd1;
                end
            end
            STOP: begin
                if (r_cnt == BIT_CNT) begin
                    w_cnt_nxt = 32'd0;
                    if (w_rx_s) begin
                        w_load      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a stuck-low RX cannot retrigger.
                w_cnt_nxt = 32'd0;
                if (w_rx_s) w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = 32'd0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_ovr_set = w_load & r_valid & ~rx_ready;

    always_ff @(posedge clock) begin
        if (!nRst) begin
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
            // A new error event takes priority over a clear in the same cycle.
            r_ferr <= w_ferr_set | (r_ferr & ~err_clr);
            r_ovr  <= w_ovr_set | (r_ovr & ~err_clr);
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
    assign interrupt = r_valid | r_ferr | r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at SYS_CLK=1600, BAUD=100 (16 cycles per bit).
module tb_uart_rx;

    localparam int unsigned SYS_CLK = 1600;
    localparam int unsigned BAUD    = 100;
    localparam int unsigned BIT_T   = 16;
    localparam int unsigned BIT_C   = 15;
    localparam int unsigned HALF_C  = 7;
    localparam int unsigned LAT     = 2 + 1 + HALF_C + 9 * (BIT_C + 1) + 1;

    logic       clock = 1'b0;
    logic       nRst;
    logic       RX;
    logic       rx_ready;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       interrupt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned t_fall   = 0;

    logic        prev_v   = 1'b0;
    int unsigned rise_cnt = 0;
    int unsigned hi_cnt   = 0;
    int unsigned t_rise   = 0;
    logic [7:0]  cap_data = 8'd0;

    uart_rx #(
        .SYS_CLK (SYS_CLK),
        .BAUD    (BAUD)
    ) dut (
        .clock     (clock),
        .nRst      (nRst),
        .RX        (RX),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .err_clr   (err_clr),
        .frame_err (frame_err),
        .overrun   (overrun),
        .interrupt (interrupt)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rx_valid) hi_cnt <= hi_cnt + 1;
        if (rx_valid && !prev_v) begin
            rise_cnt <= rise_cnt + 1;
            t_rise   <= cyc;
            cap_data <= rx_data;
        end
        prev_v <= rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic align();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int unsigned n);
        RX = b;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        t_fall = cyc;
        drive_bit(1'b0, BIT_T);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_T);
        drive_bit(stop, BIT_T);
    endtask

    task automatic pulse_ready();
        align();
        rx_ready = 1'b1;
        align();
        rx_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic pulse_clr();
        align();
        err_clr = 1'b1;
        align();
        err_clr = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int unsigned r0;
        int unsigned h0;
        int unsigned lat;
        logic [7:0]  d;
        logic [7:0]  seq [3];

        nRst     = 1'b0;
        RX       = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_data", rx_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_irq", interrupt, 0);
        align();
        nRst = 1'b1;

        // Single byte, latency window, then accept
        align();
        r0 = rise_cnt;
        send_frame(8'hA5, 1'b1);
        @(negedge clock);
        lat = t_rise - t_fall;
        check("a5_rises", rise_cnt - r0, 1);
        check("a5_lat_in_window", (lat + 1 >= LAT) && (lat <= LAT + 1), 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid", rx_valid, 1);
        check("a5_irq", interrupt, 1);
        pulse_ready();
        check("a5_acc_valid", rx_valid, 0);
        check("a5_acc_irq", interrupt, 0);

        // Back-to-back bytes without accept: overrun
        align();
        r0 = rise_cnt;
        send_frame(8'h0A, 1'b1);
        send_frame(8'hFF, 1'b1);
        @(negedge clock);
        check("ovr_rises", rise_cnt - r0, 1);
        check("ovr_data", rx_data, 8'hFF);
        check("ovr_flag", overrun, 1);
        check("ovr_valid", rx_valid, 1);
        pulse_clr();
        check("ovr_clr_flag", overrun, 0);
        check("ovr_clr_valid", rx_valid, 1);
        check("ovr_clr_data", rx_data, 8'hFF);
        pulse_ready();
        check("ovr_acc_valid", rx_valid, 0);

        // Framing error with line held low afterwards
        align();
        r0 = rise_cnt;
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 40);
        RX = 1'b1;
        @(negedge clock);
        check("fe_flag", frame_err, 1);
        check("fe_valid", rx_valid, 0);
        check("fe_irq", interrupt, 1);
        repeat (200) @(negedge clock);
        check("fe_no_retrig", rise_cnt - r0, 0);
        check("fe_valid_late", rx_valid, 0);
        pulse_clr();
        check("fe_clr_flag", frame_err, 0);
        align();
        send_frame(8'h81, 1'b1);
        @(negedge clock);
        check("fe_next_data", rx_data, 8'h81);
        check("fe_next_valid", rx_valid, 1);
        pulse_ready();

        // Short glitch aborts in START
        align();
        r0 = rise_cnt;
        drive_bit(1'b0, 4);
        RX = 1'b1;
        repeat (200) @(negedge clock);
        check("gl_rises", rise_cnt - r0, 0);
        check("gl_irq", interrupt, 0);
        check("gl_ferr", frame_err, 0);
        check("gl_ovr", overrun, 0);

        // Reset in the middle of data bit 3 of 0x55; the sender abandons the frame too
        align();
        r0 = rise_cnt;
        d  = 8'h55;
        drive_bit(1'b0, BIT_T);
        for (int i = 0; i < 3; i++) drive_bit(d[i], BIT_T);
        drive_bit(d[3], BIT_T / 2);
        nRst = 1'b0;
        align();
        nRst = 1'b1;
        RX   = 1'b1;
        @(negedge clock);
        check("mr_data", rx_data, 0);
        check("mr_valid", rx_valid, 0);
        check("mr_irq", interrupt, 0);
        repeat (200) @(negedge clock);
        check("mr_rises", rise_cnt - r0, 0);
        align();
        send_frame(8'h12, 1'b1);
        @(negedge clock);
        check("mr_next_data", rx_data, 8'h12);
        check("mr_next_valid", rx_valid, 1);
        pulse_ready();

        // Continuous accept: each byte valid for exactly one cycle
        seq[0] = 8'h01;
        seq[1] = 8'h80;
        seq[2] = 8'h00;
        align();
        rx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            r0 = rise_cnt;
            h0 = hi_cnt;
            send_frame(seq[k], 1'b1);
            @(negedge clock);
            check("ca_rises", rise_cnt - r0, 1);
            check("ca_hi_cycles", hi_cnt - h0, 1);
            check("ca_data", cap_data, seq[k]);
            check("ca_ovr", overrun, 0);
            align();
        end
        rx_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
